nibble_serial_adder: RTL

//  Multi-cycle WIDTH-bit add/subtract unit built around one cla4 slice.

---
 rtl/alu_pkg.sv | 12 +
 rtl/nibble_serial_adder_if.sv | 28 ++
 rtl/cla4.sv | 30 +++
 rtl/nibble_serial_adder.sv | 112 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
// Holds the slice width and the controller state encoding.
package alu_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Start/done handshake and result bus between the ALU result mux and the serial adder.
// The master drives operands and start; the slave answers with busy, done and the flags.
interface nibble_serial_adder_if #(
   parameter int WIDTH = 16
);

   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic             zero;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, overflow, zero
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, overflow, zero
   );

endinterface

// File: rtl/cla4.sv
// Combinational 4-bit carry-lookahead slice.
// Carries are formed directly from generate/propagate terms rather than rippled.
module cla4
   import alu_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s    = p ^ c[NIBBLE_W-1:0];
   assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one cla4 pass per nibble, LSB first, carry threaded
// between passes. Result and flags publish together on the done pulse.
module nibble_serial_adder
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   nibble_serial_adder_if.slave  bus
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = $clog2(NIBBLES);

   state_t             state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   partial_reg;
   logic               carry_reg;
   logic               done_reg;
   logic [WIDTH-1:0]   sum_reg;
   logic               cout_reg;
   logic               overflow_reg;
   logic               zero_reg;

   logic [NIBBLE_W-1:0] a_nib [NIBBLES];
   logic [NIBBLE_W-1:0] b_nib [NIBBLES];
   logic [NIBBLE_W-1:0] a_sel;
   logic [NIBBLE_W-1:0] b_sel;
   logic [NIBBLE_W-1:0] s_nib;
   logic                c_out;
   logic                last_nib;
   logic [WIDTH-1:0]    merged_sum;
   logic                cin_msb;

   generate
      for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
         assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
         assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
      end
   endgenerate

   assign a_sel = a_nib[cnt_reg];
   assign b_sel = b_nib[cnt_reg];

   cla4 u_cla4 (
      .a    (a_sel),
      .b    (b_sel),
      .cin  (carry_reg),
      .s    (s_nib),
      .cout (c_out)
   );

   assign last_nib   = (cnt_reg == CNT_W'(NIBBLES - 1));
   // Only meaningful on the last pass, where s_nib is the top nibble.
   assign merged_sum = {s_nib, partial_reg[WIDTH-NIBBLE_W-1:0]};
   assign cin_msb    = a_sel[NIBBLE_W-1] ^ b_sel[NIBBLE_W-1] ^ s_nib[NIBBLE_W-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         partial_reg  <= '0;
         carry_reg    <= 1'b0;
         done_reg     <= 1'b0;
         sum_reg      <= '0;
         cout_reg     <= 1'b0;
         overflow_reg <= 1'b0;
         zero_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  a_reg     <= bus.a;
                  b_reg     <= bus.sub ? ~bus.b : bus.b;
                  carry_reg <= bus.sub;
                  cnt_reg   <= '0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               partial_reg[NIBBLE_W*cnt_reg +: NIBBLE_W] <= s_nib;
               carry_reg <= c_out;
               cnt_reg   <= cnt_reg + 1'b1;
               if (last_nib) begin
                  cnt_reg      <= '0;
                  state_reg    <= IDLE;
                  done_reg     <= 1'b1;
                  sum_reg      <= merged_sum;
                  cout_reg     <= c_out;
                  overflow_reg <= cin_msb ^ c_out;
                  zero_reg     <= (merged_sum == '0);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.busy     = (state_reg == RUN);
   assign bus.done     = done_reg;
   assign bus.sum      = sum_reg;
   assign bus.cout     = cout_reg;
   assign bus.overflow = overflow_reg;
   assign bus.zero     = zero_reg;

endmodule
